// File: rtl/playfield_scroller_if.sv
// Bus between the line generator / VGA colour stage and playfield_scroller.
// Optional collision signals exist only when PLAYFIELD_COLLIDE_EN is defined.
`timescale 1ns/1ps
interface playfield_scroller_if #(
    parameter int WIDTH = 640,
    parameter int ROWS  = 16
);
    localparam int HW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic             scroll_tick_i;
    logic [WIDTH-1:0] line_i;
    logic [9:0]       pix_x_i;
    logic [9:0]       pix_y_i;
    logic             pixel_o;
    logic             line_req_o;
    logic [HW-1:0]    head_o;
`ifdef PLAYFIELD_COLLIDE_EN
    logic [9:0]       player_x_i;
    logic             clr_hit_i;
    logic             hit_o;
`endif

    // Scroller side
    modport slave (
        input  scroll_tick_i, line_i, pix_x_i, pix_y_i,
`ifdef PLAYFIELD_COLLIDE_EN
        input  player_x_i, clr_hit_i,
        output hit_o,
`endif
        output pixel_o, line_req_o, head_o
    );

    // Generator / colour-stage side
    modport master (
        output scroll_tick_i, line_i, pix_x_i, pix_y_i,
`ifdef PLAYFIELD_COLLIDE_EN
        output player_x_i, clr_hit_i,
        input  hit_o,
`endif
        input  pixel_o, line_req_o, head_o
    );
endinterface

// File: rtl/playfield_scroller.sv
// Scrolling playfield: circular buffer of ROWS lines, each ROW_H pixels tall,
// scrolled down one pixel per tick. A new line is committed at the top each
// time a full row has scrolled in. Registered per-pixel lookup for video.
// Optional macro PLAYFIELD_COLLIDE_EN adds a sticky player collision flag
// against the bottom visible row.
`timescale 1ns/1ps
module playfield_scroller #(
    parameter int   WIDTH = 640,
    parameter int   ROWS  = 16,
    parameter int   ROW_H = 32,
    parameter logic FILL  = 1'b1
) (
    input logic clk_i,
    input logic rst_i,
    playfield_scroller_if.slave bus
);
    localparam int HW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(ROW_H);

    logic [ROWS-1:0][WIDTH-1:0] r_slot;
    logic [HW-1:0]              r_head;
    logic [FW-1:0]              r_fine;
    logic                       r_pixel;
    logic                       r_req;

    logic                       w_commit;
    logic [10:0]                w_y;
    logic [10:0]                w_dy;
    logic [10:0]                w_k;
    logic [10:0]                w_sum;
    logic [10:0]                w_idx;
    logic                       w_x_ok;
    logic                       w_fill;
    logic                       w_k_ok;
    logic [9:0]                 w_xi;
    logic [WIDTH-1:0]           w_row;
    logic                       w_pix;

    // A tick on the last fine offset of a row commits the incoming line
    assign w_commit = bus.scroll_tick_i && (r_fine == FW'(ROW_H - 1));

    // Buffer, write pointer and fine scroll offset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot <= '1;
            r_head <= '0;
            r_fine <= '0;
        end else if (bus.scroll_tick_i) begin
            if (w_commit) begin
                r_slot[r_head] <= bus.line_i;
                r_head         <= (r_head == HW'(ROWS - 1)) ? '0 : r_head + 1'b1;
                r_fine         <= '0;
            end else begin
                r_fine <= r_fine + 1'b1;
            end
        end
    end

    // Row index math is 11 bits wide: the slot offset head+ROWS-1-k stays
    // non-negative whenever k<ROWS, and one conditional subtract folds it
    // back into 0..ROWS-1 without requiring ROWS to be a power of two.
    always_comb begin
        w_y    = {1'b0, bus.pix_y_i};
        w_dy   = w_y - 11'(r_fine);
        w_k    = w_dy >> FW;
        w_sum  = 11'(r_head) + 11'(ROWS) - 11'd1 - w_k;
        w_idx  = (w_sum >= 11'(ROWS)) ? (w_sum - 11'(ROWS)) : w_sum;
        w_x_ok = {1'b0, bus.pix_x_i} < 11'(WIDTH);
        w_fill = w_y < 11'(r_fine);
        w_k_ok = w_k < 11'(ROWS);
        w_xi   = w_x_ok ? bus.pix_x_i : '0;
        w_row  = r_slot[w_idx[HW-1:0]];
    end

    // Pixel selection: off-screen columns and rows below the band read 0
    always_comb begin
        w_pix = 1'b0;
        if (!w_x_ok)      w_pix = 1'b0;
        else if (w_fill)  w_pix = FILL;
        else if (!w_k_ok) w_pix = 1'b0;
        else              w_pix = w_row[w_xi];
    end

    // Registered lookup result and one-cycle line request after commit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pixel <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_pixel <= w_pix;
            r_req   <= w_commit;
        end
    end

    assign bus.pixel_o    = r_pixel;
    assign bus.line_req_o = r_req;
    assign bus.head_o     = r_head;

`ifdef PLAYFIELD_COLLIDE_EN
    logic             r_hit;
    logic             w_px_ok;
    logic [9:0]       w_pxi;
    logic [WIDTH-1:0] w_bot;
    logic             w_hit_now;

    // Bottom visible row (k=ROWS-1) lives at slot (head-ROWS) mod ROWS == head
    always_comb begin
        w_bot     = r_slot[r_head];
        w_px_ok   = {1'b0, bus.player_x_i} < 11'(WIDTH);
        w_pxi     = w_px_ok ? bus.player_x_i : '0;
        w_hit_now = w_px_ok && w_bot[w_pxi];
    end

    // Sticky hit flag; a fresh hit overrides a simultaneous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_hit <= 1'b0;
        else       r_hit <= w_hit_now | (r_hit & ~bus.clr_hit_i);
    end

    assign bus.hit_o = r_hit;
`else
`endif
endmodule

// File: tb/tb_playfield_scroller.sv
`timescale 1ns/1ps
module tb_playfield_scroller;
    localparam int WIDTH = 640;
    localparam int ROWS  = 4;
    localparam int ROW_H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] alt;
    logic [WIDTH-1:0] oh;

    always #5 clk = ~clk;

    playfield_scroller_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

    playfield_scroller #(.WIDTH(WIDTH), .ROWS(ROWS), .ROW_H(ROW_H), .FILL(1'b1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // One clock: drive at negedge, sample 1ns after the rising edge
    task automatic cyc(input logic tk, input logic [WIDTH-1:0] ln, input int x, input int y);
        @(negedge clk);
        bus.scroll_tick_i = tk;
        bus.line_i        = ln;
        bus.pix_x_i       = 10'(x);
        bus.pix_y_i       = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.scroll_tick_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int xs[4] = '{0, 1, 320, 639};
        bus.scroll_tick_i = 1'b0;
        bus.line_i  = '0;
        bus.pix_x_i = '0;
        bus.pix_y_i = '0;
`ifdef PLAYFIELD_COLLIDE_EN
        bus.player_x_i = 10'd700;
        bus.clr_hit_i  = 1'b0;
`endif
        rst = 1'b1;
        #12;
        checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b exp 0", bus.pixel_o); end
        checks++; if (bus.line_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.line_req_o); end
        checks++; if (bus.head_o !== 2'd0) begin errors++; $display("FAIL reset_head got %0d exp 0", bus.head_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int y = 0; y < 32; y += 7) begin
            foreach (xs[i]) begin
                cyc(1'b0, '0, xs[i], y);
                checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL reset_sweep x=%0d y=%0d got %b exp 1", xs[i], y, bus.pixel_o); end
            end
        end
        cyc(1'b0, '0, 700, 0);
        checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL reset_x700 got %b exp 0", bus.pixel_o); end
        checks++; if (bus.line_req_o !== 1'b0) begin errors++; $display("FAIL reset_req_idle got %b exp 0", bus.line_req_o); end
    endtask

    task automatic test_single_commit();
        for (int i = 0; i < WIDTH; i++) alt[i] = (i % 2 == 1);
        for (int t = 0; t < ROW_H - 1; t++) begin
            cyc(1'b1, alt, 0, 0);
            checks++; if (bus.line_req_o !== 1'b0 || bus.head_o !== 2'd0) begin errors++; $display("FAIL commit_early t=%0d req=%b head=%0d exp 0/0", t, bus.line_req_o, bus.head_o); end
        end
        cyc(1'b1, alt, 0, 0);
        checks++; if (bus.line_req_o !== 1'b1) begin errors++; $display("FAIL commit_req got %b exp 1", bus.line_req_o); end
        checks++; if (bus.head_o !== 2'd1) begin errors++; $display("FAIL commit_head got %0d exp 1", bus.head_o); end
        cyc(1'b0, '0, 1, 0);
        checks++; if (bus.line_req_o !== 1'b0) begin errors++; $display("FAIL commit_req_drop got %b exp 0", bus.line_req_o); end
        checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL commit_x1y0 got %b exp 1", bus.pixel_o); end
        cyc(1'b0, '0, 0, 0);
        checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL commit_x0y0 got %b exp 0", bus.pixel_o); end
        // latency: new address must not show before the next edge
        @(negedge clk);
        bus.pix_x_i = 10'd1;
        #1;
        checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL latency_before got %b exp 0", bus.pixel_o); end
        @(posedge clk);
        #1;
        checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL latency_after got %b exp 1", bus.pixel_o); end
    endtask

    task automatic test_fine_scroll();
        int ty[7] = '{0, 1, 2, 3, 3, 11, 10};
        int tx[7] = '{0, 0, 0, 0, 1, 0, 0};
        logic te[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            cyc(1'b1, '0, 0, 0);
            checks++; if (bus.line_req_o !== 1'b0 || bus.head_o !== 2'd1) begin errors++; $display("FAIL fine_nocommit t=%0d req=%b head=%0d exp 0/1", t, bus.line_req_o, bus.head_o); end
        end
        foreach (ty[i]) begin
            cyc(1'b0, '1, tx[i], ty[i]);
            checks++; if (bus.pixel_o !== te[i]) begin errors++; $display("FAIL fine_lookup x=%0d y=%0d got %b exp %b", tx[i], ty[i], bus.pixel_o, te[i]); end
        end
    endtask

    task automatic test_wrap();
        int tx[10] = '{4, 0, 3, 2, 1, 0, 1, 4, 0, 0};
        int ty[10] = '{0, 0, 8, 16, 24, 24, 31, 31, 8, 16};
        logic te[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            oh = '0;
            oh[c] = 1'b1;
            for (int t = 0; t < ROW_H - 1; t++) cyc(1'b1, '0, 0, 0);
            cyc(1'b1, oh, 0, 0);
            checks++; if (bus.head_o !== 2'((c + 1) % ROWS)) begin errors++; $display("FAIL wrap_head c=%0d got %0d exp %0d", c, bus.head_o, (c + 1) % ROWS); end
        end
        foreach (ty[i]) begin
            cyc(1'b0, '0, tx[i], ty[i]);
            checks++; if (bus.pixel_o !== te[i]) begin errors++; $display("FAIL wrap_lookup x=%0d y=%0d got %b exp %b", tx[i], ty[i], bus.pixel_o, te[i]); end
        end
    endtask

    task automatic test_out_of_range();
        int tx[3] = '{0, 640, 1023};
        int ty[3] = '{32, 0, 0};
        foreach (tx[i]) begin
            cyc(1'b0, '1, tx[i], ty[i]);
            checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL oor x=%0d y=%0d got %b exp 0", tx[i], ty[i], bus.pixel_o); end
        end
        for (int t = 0; t < ROW_H - 1; t++) cyc(1'b1, '1, 0, 40);
        // commit cycle: lookup sees fine=7, head=1 -> slot0 (column 4 line)
        cyc(1'b1, '0, 4, 7);
        checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL commit_cycle_lookup got %b exp 1", bus.pixel_o); end
        checks++; if (bus.line_req_o !== 1'b1 || bus.head_o !== 2'd2) begin errors++; $display("FAIL commit_cycle_state req=%b head=%0d exp 1/2", bus.line_req_o, bus.head_o); end
        cyc(1'b0, '0, 4, 7);
        checks++; if (bus.pixel_o !== 1'b0) begin errors++; $display("FAIL post_commit_lookup got %b exp 0", bus.pixel_o); end
    endtask

    task automatic test_reset_mid();
        int tx[3] = '{0, 4, 0};
        int ty[3] = '{0, 8, 16};
        for (int t = 0; t < 5; t++) cyc(1'b1, '0, 0, 0);
        checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL mid_fill got %b exp 1", bus.pixel_o); end
        @(negedge clk);
        bus.scroll_tick_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.pixel_o !== 1'b0 || bus.head_o !== 2'd0 || bus.line_req_o !== 1'b0) begin errors++; $display("FAIL mid_async pix=%b head=%0d req=%b exp 0/0/0", bus.pixel_o, bus.head_o, bus.line_req_o); end
        @(negedge clk);
        rst = 1'b0;
        foreach (tx[i]) begin
            cyc(1'b0, '0, tx[i], ty[i]);
            checks++; if (bus.pixel_o !== 1'b1) begin errors++; $display("FAIL mid_buffer x=%0d y=%0d got %b exp 1", tx[i], ty[i], bus.pixel_o); end
        end
        for (int t = 0; t < ROW_H - 1; t++) begin
            cyc(1'b1, '0, 0, 0);
            checks++; if (bus.line_req_o !== 1'b0 || bus.head_o !== 2'd0) begin errors++; $display("FAIL mid_fine_reset t=%0d req=%b head=%0d exp 0/0", t, bus.line_req_o, bus.head_o); end
        end
        cyc(1'b1, '0, 0, 0);
        checks++; if (bus.line_req_o !== 1'b1 || bus.head_o !== 2'd1) begin errors++; $display("FAIL mid_commit req=%b head=%0d exp 1/1", bus.line_req_o, bus.head_o); end
    endtask

`ifdef PLAYFIELD_COLLIDE_EN
    task automatic test_collide();
        int   px[7]  = '{700, 5, 700, 700, 5, 640, 640};
        logic clr[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic te[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        foreach (px[i]) begin
            @(negedge clk);
            bus.player_x_i = 10'(px[i]);
            bus.clr_hit_i  = clr[i];
            @(posedge clk);
            #1;
            checks++; if (bus.hit_o !== te[i]) begin errors++; $display("FAIL collide step=%0d got %b exp %b", i, bus.hit_o, te[i]); end
        end
        bus.player_x_i = 10'd700;
        bus.clr_hit_i  = 1'b0;
        for (int c = 0; c < ROWS; c++) begin
            for (int t = 0; t < ROW_H; t++) cyc(1'b1, '0, 0, 0);
            @(negedge clk);
            bus.scroll_tick_i = 1'b0;
            bus.player_x_i = 10'd5;
            @(posedge clk);
            #1;
            // bottom slot is still all ones until every slot has been rewritten
            checks++; if (bus.hit_o !== (c < ROWS - 1)) begin errors++; $display("FAIL collide_bottom c=%0d got %b exp %b", c, bus.hit_o, c < ROWS - 1); end
            @(negedge clk);
            bus.player_x_i = 10'd700;
            bus.clr_hit_i  = 1'b1;
            @(negedge clk);
            bus.clr_hit_i  = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_commit();
        test_fine_scroll();
        test_wrap();
        test_out_of_range();
        test_reset_mid();
`ifdef PLAYFIELD_COLLIDE_EN
        test_collide();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
